half_adder_bist: RTL and testbench
==================================

// Module: half_adder_bist
// PURPOSE
//  On-chip stimulus driver and response checker for a half-adder datapath.
//  Generates operand pairs, drives them to the adder, samples sum/carry, compares to
//  a golden model and reports pass/fail with an error count. Sits beside the adder
//  inside the tt_um top level and replaces bench-side driving for silicon bring-up.
// PARAMETERS
//  N_VECTORS      16     vectors per run; >=4; first 4 are always exhaustive
//  SETTLE_CYCLES  1      cycles operands are held before sampling; >=1
//  ERR_W          4      error-counter width; counter saturates at 2**ERR_W-1
//  LFSR_SEED      8'hA5  nonzero seed for the 8-bit LFSR
// PORTS
//  clk        in   1      single clock, all logic rising-edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      begin a run; sampled only in IDLE or DONE
//  dut_a      out  1      operand A to adder
//  dut_b      out  1      operand B to adder
//  dut_sum    in   1      adder sum response
//  dut_carry  in   1      adder carry response
//  busy       out  1      high while a run is in progress
//  done       out  1      level; high from end of run until next accepted start
//  pass       out  1      done && err_count==0
//  err_count  out  ERR_W  mismatching vectors this run, saturating
// BEHAVIOUR
//  - Reset: dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, FSM=IDLE, LFSR=LFSR_SEED.
//    Reset mid-run aborts immediately; no partial result is retained.
//  - FSM: IDLE -start-> DRIVE; DRIVE holds SETTLE_CYCLES cycles -> SAMPLE (1 cycle);
//    SAMPLE -> DRIVE of next vector, or -> DONE after vector N_VECTORS-1.
//    DONE -start-> DRIVE (clears err_count, vector index, reloads LFSR_SEED).
//  - start in DRIVE/SAMPLE is ignored. start and rst same cycle: rst wins.
//  - Vector k<4: {dut_a,dut_b}=k[1:0] (00,01,10,11). k>=4: dut_a=lfsr[0], dut_b=lfsr[1];
//    LFSR (x^8+x^6+x^5+x^4+1, Fibonacci, shift left) advances once per SAMPLE at k>=3.
//  - dut_a/dut_b registered; stable for all DRIVE and SAMPLE cycles of a vector.
//  - SAMPLE compares {dut_carry,dut_sum} to {a&b, a^b}; mismatch increments err_count
//    unless already all-ones (saturate, no wrap).
//  - Timing: start accepted at edge 0; busy rises same edge; done rises at edge
//    N_VECTORS*(SETTLE_CYCLES+1)+... exactly N_VECTORS*(SETTLE_CYCLES+1) cycles after
//    busy rises; busy and done never high together.
//  - In IDLE/DONE dut_a/dut_b hold 0.
// CONFIGURATION
//  HA_BIST_FIRST_FAIL_EN defined: extra output first_fail_idx [7:0] plus first_fail_vld;
//    captures index k of first mismatching vector in a run; both clear on reset or new
//    start; later mismatches do not overwrite.
//  Undefined: ports absent, no capture logic; all other behaviour identical.
// STRUCTURE
//  Package ha_bist_pkg: FSM state enum (IDLE, DRIVE, SAMPLE, DONE), LFSR tap mask
//    constant, golden half-adder function ha_golden(a,b) -> {carry,sum}.
//  Sub-module ha_bist_lfsr: 8-bit LFSR with load (seed) and advance enables.
//  Top: FSM, settle counter, vector index counter, compare, error counter.
// TESTING
//  1 Correct adder, defaults, pulse start -> busy 32 cycles, done=1, pass=1, err_count=0.
//  2 Adder with carry stuck-at-0 -> only vector 3 and LFSR vectors with a=b=1 fail;
//    err_count equals bench golden count; pass=0; first_fail_idx=3 when macro set.
//  3 Sum inverted, ERR_W=2, N_VECTORS=16 -> err_count saturates at 3, no wrap.
//  4 Assert rst at cycle 10 of a run -> next cycle all outputs at reset values;
//    subsequent start gives full clean run.
//  5 start held high throughout -> one run; re-start only on DONE, err_count cleared.
//  6 SETTLE_CYCLES=3 -> each vector held 4 cycles; done after 64 cycles; first four
//    vectors observed on dut_a/dut_b as 00,01,10,11.

Source files
------------

// File: rtl/ha_bist_pkg.sv
// ============================================================================
// Module : ha_bist_pkg
// Brief  : Shared types, LFSR taps and golden half-adder model for the BIST.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ha_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } ha_bist_state_t;

    // x^8 + x^6 + x^5 + x^4 + 1, taken from state bits 7,5,4,3 when shifting left
    localparam logic [7:0] c_LFSR_TAPS = 8'hB8;

    function automatic logic [1:0] ha_golden(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ha_bist_lfsr.sv
// ============================================================================
// Module : ha_bist_lfsr
// Brief  : 8-bit Fibonacci LFSR (shift left) with seed load and advance enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ha_bist_lfsr
    import ha_bist_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_advance,
    output logic [7:0] o_next
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb   = ^(r_lfsr & c_LFSR_TAPS);
    assign o_next = {r_lfsr[6:0], w_fb};

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_lfsr <= SEED;
        end else if (i_advance) begin
            r_lfsr <= o_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/half_adder_bist.sv
// ============================================================================
// Module : half_adder_bist
// Brief  : Stimulus driver / response checker for a half adder. Optional
//          first-failure capture is enabled by HA_BIST_FIRST_FAIL_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module half_adder_bist
    import ha_bist_pkg::*;
#(
    parameter int         N_VECTORS     = 16,
    parameter int         SETTLE_CYCLES = 1,
    parameter int         ERR_W         = 4,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_sum,
    input  logic             dut_carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef HA_BIST_FIRST_FAIL_EN
    ,
    output logic [7:0]       first_fail_idx,
    output logic             first_fail_vld
`endif
);

    localparam int c_IDX_W = $clog2(N_VECTORS);
    localparam int c_SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    ha_bist_state_t     r_state;
    ha_bist_state_t     w_state_nxt;
    logic               w_start_acc;
    logic [c_SET_W-1:0] r_settle;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_a;
    logic               r_b;
    logic [ERR_W-1:0]   r_err;
    logic               w_settle_end;
    logic               w_last;
    logic               w_exhaustive;
    logic               w_mismatch;
    logic [1:0]         w_vec_lo;
    logic [7:0]         w_lfsr_nxt;

    assign w_settle_end = (r_settle == c_SET_W'(SETTLE_CYCLES - 1));
    assign w_last       = (r_idx == c_IDX_W'(N_VECTORS - 1));
    // True while the next vector is still one of the four exhaustive ones
    assign w_exhaustive = (r_idx < c_IDX_W'(3));
    assign w_vec_lo     = r_idx[1:0] + 2'd1;
    assign w_mismatch   = ({dut_carry, dut_sum} != ha_golden(r_a, r_b));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_DRIVE;
                    w_start_acc = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (w_settle_end) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_state_nxt = w_last ? ST_DONE : ST_DRIVE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The LFSR moves at the same edge that loads the next operands, so
    // LFSR-driven vectors are taken from its next value.
    ha_bist_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_start_acc),
        .i_advance ((r_state == ST_SAMPLE) && !w_exhaustive),
        .o_next    (w_lfsr_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_settle <= '0;
            r_idx    <= '0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_err    <= '0;
        end else if (r_state == ST_DRIVE) begin
            r_settle <= w_settle_end ? '0 : r_settle + 1'b1;
        end else if (r_state == ST_SAMPLE) begin
            if (w_mismatch && (r_err != '1)) begin
                r_err <= r_err + 1'b1;
            end
            if (w_last) begin
                r_a <= 1'b0;
                r_b <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
                if (w_exhaustive) begin
                    r_a <= w_vec_lo[1];
                    r_b <= w_vec_lo[0];
                end else begin
                    r_a <= w_lfsr_nxt[0];
                    r_b <= w_lfsr_nxt[1];
                end
            end
        end
    end

`ifdef HA_BIST_FIRST_FAIL_EN
    logic [7:0] r_ff_idx;
    logic       r_ff_vld;

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_ff_idx <= '0;
            r_ff_vld <= 1'b0;
        end else if ((r_state == ST_SAMPLE) && w_mismatch && !r_ff_vld) begin
            r_ff_idx <= 8'(r_idx);
            r_ff_vld <= 1'b1;
        end
    end

    assign first_fail_idx = r_ff_idx;
    assign first_fail_vld = r_ff_vld;
`endif

    assign dut_a     = r_a;
    assign dut_b     = r_b;
    assign busy      = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
    assign done      = (r_state == ST_DONE);
    assign pass      = (r_state == ST_DONE) && (r_err == '0);
    assign err_count = r_err;

endmodule

`default_nettype wire

// File: tb/tb_half_adder_bist.sv
// ============================================================================
// Module : tb_half_adder_bist
// Brief  : Randomized self-checking bench for half_adder_bist with a
//          behavioural vector/error model and three parameterisations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_half_adder_bist;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s [3];
    logic       a_s     [3];
    logic       b_s     [3];
    logic       sum_s   [3];
    logic       carry_s [3];
    logic       busy_s  [3];
    logic       done_s  [3];
    logic       pass_s  [3];
    logic [7:0] ffi_s   [3];
    logic       ffv_s   [3];
    logic [3:0] err0;
    logic [1:0] err1;
    logic [3:0] err2;
    int         fault_s [3];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         overlap  = 0;
    int         cyc;

    always #5 clk = ~clk;

    // Adder under test: 0 = correct, 1 = carry stuck-at-0, 2 = sum inverted
    always_comb begin
        for (int d = 0; d < 3; d++) begin
            sum_s[d]   = (a_s[d] ^ b_s[d]) ^ (fault_s[d] == 2);
            carry_s[d] = (fault_s[d] == 1) ? 1'b0 : (a_s[d] & b_s[d]);
        end
    end

    half_adder_bist #(.N_VECTORS(N), .SETTLE_CYCLES(1), .ERR_W(4), .LFSR_SEED(8'hA5)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .dut_a(a_s[0]), .dut_b(b_s[0]),
        .dut_sum(sum_s[0]), .dut_carry(carry_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pass(pass_s[0]), .err_count(err0)
`ifdef HA_BIST_FIRST_FAIL_EN
        , .first_fail_idx(ffi_s[0]), .first_fail_vld(ffv_s[0])
`endif
    );

    half_adder_bist #(.N_VECTORS(N), .SETTLE_CYCLES(1), .ERR_W(2), .LFSR_SEED(8'hA5)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .dut_a(a_s[1]), .dut_b(b_s[1]),
        .dut_sum(sum_s[1]), .dut_carry(carry_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pass(pass_s[1]), .err_count(err1)
`ifdef HA_BIST_FIRST_FAIL_EN
        , .first_fail_idx(ffi_s[1]), .first_fail_vld(ffv_s[1])
`endif
    );

    half_adder_bist #(.N_VECTORS(N), .SETTLE_CYCLES(3), .ERR_W(4), .LFSR_SEED(8'hA5)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_s[2]), .dut_a(a_s[2]), .dut_b(b_s[2]),
        .dut_sum(sum_s[2]), .dut_carry(carry_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .pass(pass_s[2]), .err_count(err2)
`ifdef HA_BIST_FIRST_FAIL_EN
        , .first_fail_idx(ffi_s[2]), .first_fail_vld(ffv_s[2])
`endif
    );

`ifndef HA_BIST_FIRST_FAIL_EN
    always_comb begin
        for (int d = 0; d < 3; d++) begin
            ffi_s[d] = 8'd0;
            ffv_s[d] = 1'b0;
        end
    end
`endif

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (busy_s[d] && done_s[d]) overlap++;
        end
    end

    function automatic int settle_of(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    function automatic int err_max(input int d);
        return (d == 1) ? 3 : 15;
    endfunction

    function automatic int err_of(input int d);
        case (d)
            0:       return int'(err0);
            1:       return int'(err1);
            default: return int'(err2);
        endcase
    endfunction

    function automatic int lfsr_step(input int s);
        int fb;
        fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
        return ((s << 1) | fb) & 255;
    endfunction

    // {a,b} of vector k: exhaustive first, then LFSR after (k-3) steps
    function automatic int model_vec(input int k);
        int s;
        if (k < 4) return k;
        s = 'hA5;
        for (int i = 0; i < k - 3; i++) s = lfsr_step(s);
        return ((s & 1) << 1) | ((s >> 1) & 1);
    endfunction

    function automatic bit model_fails(input int k, input int mode);
        int v, a, b;
        v = model_vec(k);
        a = (v >> 1) & 1;
        b = v & 1;
        if (mode == 1) return (a & b) == 1;
        if (mode == 2) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic run_dut(input int d, input int mode, input string tag);
        int c, s1, k, bad, seq, exp_err, exp_ff, v;
        s1 = settle_of(d) + 1;
        fault_s[d] = mode;
        @(negedge clk);
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
        check({tag, "_busy_rise"}, int'(busy_s[d]), 1);
        c = 0;
        bad = 0;
        seq = 0;
        while (busy_s[d] && c < 8 * N * s1) begin
            k = c / s1;
            v = model_vec(k);
            if (int'({a_s[d], b_s[d]}) != v) bad++;
            if ((c % s1 == 0) && k < 4) seq = (seq << 2) | int'({a_s[d], b_s[d]});
            @(negedge clk);
            c++;
        end
        exp_err = 0;
        exp_ff  = -1;
        for (int i = 0; i < N; i++) begin
            if (model_fails(i, mode)) begin
                if (exp_err < err_max(d)) exp_err++;
                if (exp_ff < 0) exp_ff = i;
            end
        end
        check({tag, "_busy_len"}, c, N * s1);
        check({tag, "_vec_errs"}, bad, 0);
        check({tag, "_first4"}, seq, 'h1B);
        check({tag, "_done"}, int'({busy_s[d], done_s[d]}), 1);
        check({tag, "_err"}, err_of(d), exp_err);
        check({tag, "_pass"}, int'(pass_s[d]), (exp_err == 0) ? 1 : 0);
        check({tag, "_ab_idle"}, int'({a_s[d], b_s[d]}), 0);
`ifdef HA_BIST_FIRST_FAIL_EN
        check({tag, "_ff_vld"}, int'(ffv_s[d]), (exp_ff >= 0) ? 1 : 0);
        if (exp_ff >= 0) check({tag, "_ff_idx"}, int'(ffi_s[d]), exp_ff);
`endif
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            fault_s[d] = 0;
        end
        repeat (3) @(negedge clk);
        check("reset_outs", int'({a_s[0], b_s[0], busy_s[0], done_s[0], pass_s[0]}), 0);
        check("reset_err", err_of(0), 0);
        rst = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);

        run_dut(0, 0, "good");
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run_dut(0, 1, "carry_sa0");

        // start held high: one run at a time, restart only from DONE
        fault_s[0] = 0;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        check("hold_err_clear", err_of(0), 0);
        cyc = 0;
        while (busy_s[0] && cyc < 200) begin @(negedge clk); cyc++; end
        check("hold_busy_len", cyc, 2 * N);
        check("hold_done", int'(done_s[0]), 1);
        @(negedge clk);
        check("hold_restart", int'({busy_s[0], done_s[0]}), 2);
        start_s[0] = 1'b0;
        cyc = 0;
        while (busy_s[0] && cyc < 200) begin @(negedge clk); cyc++; end
        check("hold_busy_len2", cyc, 2 * N);
        check("hold_pass", int'(pass_s[0]), 1);

        // reset in the middle of a faulty run
        fault_s[0] = 1;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outs", int'({a_s[0], b_s[0], busy_s[0], done_s[0], pass_s[0]}), 0);
        check("midrst_err", err_of(0), 0);
        check("midrst_ff", int'(ffv_s[0]), 0);
        rst = 1'b0;
        run_dut(0, 0, "post_rst");

        run_dut(1, 2, "sum_inv_sat");
        run_dut(2, $urandom_range(0, 1), "settle3");

        check("busy_done_overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
